// File: rtl/landing_judge_pkg.sv
// landing_judge_pkg: shared types and geometry for the landing judge.
// FSM state encoding, default ground/target geometry, BCD width.
package landing_judge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FLIGHT = 2'b01,
    RESULT = 2'b10
  } state_t;

  localparam int GROUND_Y_DEF    = 450;
  localparam int TARGET_X_LO_DEF = 420;
  localparam int TARGET_X_HI_DEF = 540;
  localparam int BCD_W           = 8;

  function automatic logic [6:0] bcd_to_bin(
    input logic [BCD_W-1:0] b
  );
    return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
  endfunction

endpackage

// File: rtl/bcd_counter_2d.sv
// bcd_counter_2d: two-digit BCD incrementer, saturating at 99.
// Sync active-low clear; counts one step per inc strobe.
module bcd_counter_2d
  import landing_judge_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [BCD_W-1:0] q
);

  // ones roll 9->0 with carry into tens; 99 holds
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (inc && q != 8'h99) begin
      if (q[3:0] == 4'd9) q <= {q[7:4] + 4'd1, 4'd0};
      else                q <= {q[7:4], q[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/landing_judge.sv
// landing_judge: detects ground contact of the ball, judges hit/miss.
// Optional tally-bar overlay output score_px under SCORE_OVERLAY_EN.
module landing_judge
  import landing_judge_pkg::*;
#(
  parameter int GROUND_Y          = GROUND_Y_DEF,
  parameter int TARGET_X_LO       = TARGET_X_LO_DEF,
  parameter int TARGET_X_HI       = TARGET_X_HI_DEF,
  parameter int MAX_FLIGHT_FRAMES = 255,
  parameter int RESULT_FRAMES     = 60
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             update,
  input  logic             go,
  input  logic [9:0]       x_count,
  input  logic [9:0]       y_count,
  input  logic             ball,
`ifdef SCORE_OVERLAY_EN
  output logic             score_px,
`endif
  output logic             hit_pulse,
  output logic             miss_pulse,
  output logic [BCD_W-1:0] score_bcd,
  output logic [BCD_W-1:0] throws_bcd,
  output logic             result_flash,
  output logic             busy
);

  state_t     state, state_n;
  logic [7:0] frame_cnt, cnt_n;
  logic       hit_n, miss_n;
  logic       contact_acc, tgt_acc;
  logic       contact_term, tgt_term;
  logic       contact_now, tgt_now;

  assign contact_term = ball && (y_count >= 10'(GROUND_Y));
  assign tgt_term = contact_term
                 && (x_count > 10'(TARGET_X_LO))
                 && (x_count < 10'(TARGET_X_HI));
  assign contact_now = contact_acc | contact_term;
  assign tgt_now     = tgt_acc | tgt_term;

  // per-frame sticky flags; update pixel belongs to closing frame
  always_ff @(posedge clk) begin
    if (!rst || update) begin
      contact_acc <= 1'b0;
      tgt_acc     <= 1'b0;
    end else begin
      contact_acc <= contact_now;
      tgt_acc     <= tgt_now;
    end
  end

  // state, frame counter and verdict pulse registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      frame_cnt  <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      frame_cnt  <= cnt_n;
      hit_pulse  <= hit_n;
      miss_pulse <= miss_n;
    end
  end

  // next state; go-low abort in flight beats any verdict
  always_comb begin
    state_n = state;
    cnt_n   = frame_cnt;
    hit_n   = 1'b0;
    miss_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (update && go) begin
          state_n = FLIGHT;
          cnt_n   = '0;
        end
      end
      FLIGHT: begin
        if (!go) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (update) begin
          if (contact_now) begin
            hit_n   = tgt_now;
            miss_n  = !tgt_now;
            state_n = RESULT;
            cnt_n   = '0;
          end else if (frame_cnt == 8'(MAX_FLIGHT_FRAMES)) begin
            miss_n  = 1'b1;
            state_n = RESULT;
            cnt_n   = '0;
          end else begin
            cnt_n = frame_cnt + 8'd1;
          end
        end
      end
      RESULT: begin
        if (update) begin
          if (frame_cnt == 8'(RESULT_FRAMES - 1)) begin
            if (!go) begin
              state_n = IDLE;
              cnt_n   = '0;
            end
          end else begin
            cnt_n = frame_cnt + 8'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // status outputs decoded from state
  always_comb begin
    busy         = (state != IDLE);
    result_flash = (state == RESULT) && !frame_cnt[3];
  end

  bcd_counter_2d u_score (
    .clk (clk),
    .rst (rst),
    .inc (hit_n),
    .q   (score_bcd)
  );

  bcd_counter_2d u_throws (
    .clk (clk),
    .rst (rst),
    .inc (hit_n | miss_n),
    .q   (throws_bcd)
  );

`ifdef SCORE_OVERLAY_EN
  logic [9:0] xo;
  logic [6:0] sc_bin, bars;

  assign xo     = x_count - 10'd8;
  assign sc_bin = bcd_to_bin(score_bcd);
  assign bars   = (sc_bin > 7'd40) ? 7'd40 : sc_bin;

  // tally bars: 4 px wide on an 8 px pitch, rows 8..23
  always_ff @(posedge clk) begin
    if (!rst) begin
      score_px <= 1'b0;
    end else begin
      score_px <= (y_count >= 10'd8) && (y_count <= 10'd23)
               && (x_count >= 10'd8) && !xo[2]
               && (xo[9:3] < bars);
    end
  end
`endif

endmodule

// File: doc/landing_judge.md
Name: landing_judge

Overview:
- Downstream of the ball stage.
- Watches the raster-aligned ball pixel each frame and detects the frame in which the ball first touches the ground band.
- Judges the throw as a hit or a miss against the target window and keeps a two-digit BCD score and throw count for the display stage.
- Runs on the VGA pixel clock and uses the per-frame update pulse.

Parameters:
- GROUND_Y, 450, first ground row; a ball pixel with y_count >= GROUND_Y is ground contact.
- TARGET_X_LO, 420, target window exclusive lower bound (x_count > TARGET_X_LO).
- TARGET_X_HI, 540, target window exclusive upper bound (x_count < TARGET_X_HI).
- MAX_FLIGHT_FRAMES, 255, number of frames without contact before the throw is judged a miss.
- RESULT_FRAMES, 60, number of frames the result is held before re-arming.

Ports:
- clk  in  1  VGA pixel clock
- rst  in  1  synchronous reset, active-low
- update  in  1  one-cycle end-of-frame pulse
- go  in  1  throw switch; high = throw in progress
- x_count  in  10  raster column
- y_count  in  10  raster row
- ball  in  1  ball pixel, aligned with x_count/y_count of the same cycle
- hit_pulse  out  1  one-cycle pulse on a hit verdict
- miss_pulse  out  1  one-cycle pulse on a miss verdict
- score_bcd  out  8  hits, BCD {tens, ones}
- throws_bcd  out  8  judged throws, BCD {tens, ones}
- result_flash  out  1  blinks while a result is held
- busy  out  1  high in FLIGHT or RESULT

Behaviour:
- Reset (rst low at a clk edge): state IDLE; all outputs 0; accumulators and frame counter cleared. Reset mid-flight discards the throw with no pulse.
- Per-pixel accumulators, updated every clk:
  - contact |= ball && y_count >= GROUND_Y
  - in_tgt |= contact term && x_count > TARGET_X_LO && x_count < TARGET_X_HI
- On an update cycle, evaluation uses (accumulator | this cycle's term). Both accumulators then clear, so the update-cycle pixel belongs to the closing frame.
- The FSM advances only on update cycles, except for the go-low abort.
- States:
  - IDLE: when go is high at update, go to FLIGHT; frame_cnt = 0.
  - FLIGHT:
    - If contact and in_tgt: HIT.
    - If contact and not in_tgt: MISS.
    - If no contact and frame_cnt == MAX_FLIGHT_FRAMES: MISS (ball off-screen).
    - Otherwise frame_cnt++.
    - Verdict: go to RESULT, frame_cnt = 0.
  - RESULT: frame_cnt++. When frame_cnt == RESULT_FRAMES-1 and go is low, go to IDLE. If go is still high, stay in RESULT with the counter held; no re-throw until go is cycled low.
  - go low in FLIGHT on any clk: abort to IDLE on the next edge; no pulse, counters unchanged.
- Verdict effects: the pulse is asserted the cycle after the update edge, for exactly one cycle. throws_bcd increments on both verdicts; score_bcd increments on hit only. Both outputs are registered and change on that same cycle.
- BCD rule: ones 9 to 0 carries into tens. 99 saturates at 99; there is no wrap.
- result_flash = RESULT state && frame_cnt[3] == 0. busy = state != IDLE.
- Contact with the target window spanning several pixels in one frame gives one verdict only.

Optional Feature:
- Macro: SCORE_OVERLAY_EN.
- Defined: adds output score_px (1 bit, registered, one clk latency).
  - score_px is high for tally bars at rows 8..23.
  - Bar k (k = 0..score-1, score capped at 40 bars) covers x_count in [8+8k, 8+8k+3].
  - The score used is the binary equivalent of score_bcd.
- Undefined: the port is absent, with no logic generated.

Decomposition:
- Package landing_judge_pkg holds:
  - the state enum IDLE/FLIGHT/RESULT, 2-bit encoding 00/01/10
  - default geometry constants 450/420/540
  - the BCD width constant
- Sub-module bcd_counter_2d: 8-bit saturating two-digit BCD incrementer with sync active-low clear and an inc strobe. It is instantiated twice, for score and throws.

Test Plan:
- Hit: go=1. After 3 frames, ball pixels at y=455, x=480 → hit_pulse one cycle after that update; score_bcd=0x01, throws_bcd=0x01, busy=1, result_flash blinking.
- Miss on ground: contact at y=460, x=300 → miss_pulse; score 0x00, throws 0x01.
- Timeout: go=1 with ball never at or below row 450 for 256 frames → miss_pulse after update 256; throws 0x01.
- Saturation: drive 100 hits with go cycled between throws → score_bcd stays 0x99 after the 99th hit, throws_bcd stays 0x99.
- Abort/reset: drop go mid-FLIGHT → IDLE, no pulse, counts unchanged. rst low during RESULT → all outputs 0 next edge.
- Boundary: contact only at x=420 → miss; contact only at x=421 → hit; contact pixel coinciding with the update cycle → verdict on that update.
